// File: rtl/qdr_arb_pkg.sv
// qdr_arbiter shared types and constants.
// Round-robin arbitration is enabled by defining QDR_ARB_RR_EN.
package qdr_arb_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int TAG_DEPTH_DEF = 16;
  localparam int CNT_W_DEF = $clog2(TAG_DEPTH_DEF) + 1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/qdr_arb_tag_fifo.sv
// 1-bit tag FIFO holding the port id of every outstanding read.
// A push into a full FIFO is taken only when a pop frees a slot that cycle.
module qdr_arb_tag_fifo
  import qdr_arb_pkg::*;
#(
  parameter int TAG_DEPTH = TAG_DEPTH_DEF,
  localparam int CW = cnt_w(TAG_DEPTH),
  localparam int PW = $clog2(TAG_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic          mem [TAG_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(TAG_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/qdr_arbiter.sv
// Two-port arbiter in front of the QDR controller user interface.
// Define QDR_ARB_RR_EN for round-robin; default is fixed priority to A.
module qdr_arbiter
  import qdr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int BW_WIDTH   = 2,
  parameter int ADDR_WIDTH = 22,
  parameter int TAG_DEPTH  = TAG_DEPTH_DEF
) (
  input  logic                    clk0,
  input  logic                    reset,
  input  logic                    phy_rdy,
  input  logic                    a_req,
  input  logic                    a_wr,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [2*DATA_WIDTH-1:0] a_wr_data,
  input  logic [2*BW_WIDTH-1:0]   a_wr_be,
  output logic                    a_ack,
  output logic [2*DATA_WIDTH-1:0] a_rd_data,
  output logic                    a_rd_dvld,
  input  logic                    b_req,
  input  logic                    b_wr,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [2*DATA_WIDTH-1:0] b_wr_data,
  input  logic [2*BW_WIDTH-1:0]   b_wr_be,
  output logic                    b_ack,
  output logic [2*DATA_WIDTH-1:0] b_rd_data,
  output logic                    b_rd_dvld,
  output logic                    usr_rd_strb,
  output logic                    usr_wr_strb,
  output logic [ADDR_WIDTH-1:0]   usr_addr,
  output logic [2*DATA_WIDTH-1:0] usr_wr_data,
  output logic [2*BW_WIDTH-1:0]   usr_wr_be,
  input  logic [2*DATA_WIDTH-1:0] usr_rd_data,
  input  logic                    usr_rd_dvld,
  output logic                    tag_err
);

  localparam int CW = cnt_w(TAG_DEPTH);

  logic          full;
  logic          empty;
  logic          tag;
  logic [CW-1:0] count;
  logic          a_elig;
  logic          b_elig;
  logic          gnt;
  logic          sel_wr;
  logic          push;

  // full uses the registered count; a same-cycle pop does not unblock
  assign a_elig = !reset && a_req && phy_rdy && (a_wr || !full);
  assign b_elig = !reset && b_req && phy_rdy && (b_wr || !full);

`ifdef QDR_ARB_RR_EN
  logic last;

  assign a_ack = a_elig && (!b_elig || last == PORT_B);
  assign b_ack = b_elig && !a_ack;

  always_ff @(posedge clk0) begin
    if (reset)      last <= PORT_B;
    else if (a_ack) last <= PORT_A;
    else if (b_ack) last <= PORT_B;
  end
`else
  assign a_ack = a_elig;
  assign b_ack = b_elig && !a_elig;
`endif

  assign gnt    = a_ack || b_ack;
  assign sel_wr = b_ack ? b_wr : a_wr;
  assign push   = gnt && !sel_wr;

  qdr_arb_tag_fifo #(
    .TAG_DEPTH(TAG_DEPTH)
  ) u_fifo (
    .clk  (clk0),
    .reset(reset),
    .push (push),
    .pop  (usr_rd_dvld),
    .din  (b_ack ? PORT_B : PORT_A),
    .dout (tag),
    .count(count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk0) begin
    if (reset) begin
      usr_rd_strb <= 1'b0;
      usr_wr_strb <= 1'b0;
      usr_addr    <= '0;
      usr_wr_data <= '0;
      usr_wr_be   <= '0;
    end else begin
      usr_rd_strb <= gnt && !sel_wr;
      usr_wr_strb <= gnt && sel_wr;
      if (gnt) begin
        usr_addr    <= b_ack ? b_addr : a_addr;
        usr_wr_data <= b_ack ? b_wr_data : a_wr_data;
        usr_wr_be   <= b_ack ? b_wr_be : a_wr_be;
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      a_rd_data <= '0;
      b_rd_data <= '0;
      a_rd_dvld <= 1'b0;
      b_rd_dvld <= 1'b0;
      tag_err   <= 1'b0;
    end else begin
      a_rd_dvld <= usr_rd_dvld && !empty && tag == PORT_A;
      b_rd_dvld <= usr_rd_dvld && !empty && tag == PORT_B;
      tag_err   <= usr_rd_dvld && empty;
      if (usr_rd_dvld && !empty) begin
        a_rd_data <= usr_rd_data;
        b_rd_data <= usr_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_qdr_arbiter.sv
// Directed self-checking bench for qdr_arbiter.
// Honors QDR_ARB_RR_EN for the contention expectations.
module tb_qdr_arbiter;
  import qdr_arb_pkg::*;

  localparam int DW = 18;
  localparam int BW = 2;
  localparam int AW = 22;

  logic          clk0 = 1'b0;
  logic          reset;
  logic          phy_rdy;
  logic          a_req, a_wr, a_ack, a_rd_dvld;
  logic [AW-1:0] a_addr;
  logic [2*DW-1:0] a_wr_data, a_rd_data;
  logic [2*BW-1:0] a_wr_be;
  logic          b_req, b_wr, b_ack, b_rd_dvld;
  logic [AW-1:0] b_addr;
  logic [2*DW-1:0] b_wr_data, b_rd_data;
  logic [2*BW-1:0] b_wr_be;
  logic          usr_rd_strb, usr_wr_strb;
  logic [AW-1:0] usr_addr;
  logic [2*DW-1:0] usr_wr_data, usr_rd_data;
  logic [2*BW-1:0] usr_wr_be;
  logic          usr_rd_dvld, tag_err;

  logic       f_push, f_pop, f_din, f_dout;
  logic [4:0] f_count;
  logic       f_full, f_empty;

  int total = 0;
  int bad   = 0;
  int errs;

  always #5 clk0 = ~clk0;

  qdr_arbiter dut (
    .clk0       (clk0),
    .reset      (reset),
    .phy_rdy    (phy_rdy),
    .a_req      (a_req),
    .a_wr       (a_wr),
    .a_addr     (a_addr),
    .a_wr_data  (a_wr_data),
    .a_wr_be    (a_wr_be),
    .a_ack      (a_ack),
    .a_rd_data  (a_rd_data),
    .a_rd_dvld  (a_rd_dvld),
    .b_req      (b_req),
    .b_wr       (b_wr),
    .b_addr     (b_addr),
    .b_wr_data  (b_wr_data),
    .b_wr_be    (b_wr_be),
    .b_ack      (b_ack),
    .b_rd_data  (b_rd_data),
    .b_rd_dvld  (b_rd_dvld),
    .usr_rd_strb(usr_rd_strb),
    .usr_wr_strb(usr_wr_strb),
    .usr_addr   (usr_addr),
    .usr_wr_data(usr_wr_data),
    .usr_wr_be  (usr_wr_be),
    .usr_rd_data(usr_rd_data),
    .usr_rd_dvld(usr_rd_dvld),
    .tag_err    (tag_err)
  );

  qdr_arb_tag_fifo #(
    .TAG_DEPTH(16)
  ) u_tf (
    .clk  (clk0),
    .reset(reset),
    .push (f_push),
    .pop  (f_pop),
    .din  (f_din),
    .dout (f_dout),
    .count(f_count),
    .full (f_full),
    .empty(f_empty)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  initial begin
    reset = 1; phy_rdy = 0;
    a_req = 0; a_wr = 0; a_addr = '0;
    a_wr_data = '0; a_wr_be = '0;
    b_req = 0; b_wr = 0; b_addr = '0;
    b_wr_data = '0; b_wr_be = '0;
    usr_rd_data = '0; usr_rd_dvld = 0;
    f_push = 0; f_pop = 0; f_din = 0;
    tick(); tick();
    reset = 0;
    chk("rst_rd_strb", 64'(usr_rd_strb), 0);
    chk("rst_wr_strb", 64'(usr_wr_strb), 0);
    chk("rst_addr", 64'(usr_addr), 0);
    chk("rst_a_dvld", 64'(a_rd_dvld), 0);
    chk("rst_tag_err", 64'(tag_err), 0);

    // phy not ready: nothing acked
    a_req = 1; a_wr = 1; b_req = 1; b_wr = 0;
    #1;
    chk("nophy_a_ack", 64'(a_ack), 0);
    chk("nophy_b_ack", 64'(b_ack), 0);
    tick();
    chk("nophy_wr", 64'(usr_wr_strb), 0);
    chk("nophy_rd", 64'(usr_rd_strb), 0);
    a_req = 0; b_req = 0;

    // single write from A
    phy_rdy = 1;
    a_req = 1; a_wr = 1; a_addr = 22'h10;
    a_wr_data = 36'h123456789; a_wr_be = 4'hF;
    #1;
    chk("sgl_a_ack", 64'(a_ack), 1);
    chk("sgl_b_ack", 64'(b_ack), 0);
    tick();
    a_req = 0;
    chk("sgl_wr_strb", 64'(usr_wr_strb), 1);
    chk("sgl_rd_strb", 64'(usr_rd_strb), 0);
    chk("sgl_addr", 64'(usr_addr), 64'h10);
    chk("sgl_data", 64'(usr_wr_data), 64'h123456789);
    chk("sgl_be", 64'(usr_wr_be), 64'hF);
    chk("sgl_count", 64'(dut.u_fifo.count), 0);

    // read routing: B then A, data returns in order
    b_req = 1; b_wr = 0; b_addr = 22'h3;
    #1;
    chk("rt_b_ack", 64'(b_ack), 1);
    tick();
    b_req = 0;
    a_req = 1; a_wr = 0; a_addr = 22'h7;
    #1;
    chk("rt_a_ack", 64'(a_ack), 1);
    chk("rt_strb1", 64'(usr_rd_strb), 1);
    chk("rt_addr1", 64'(usr_addr), 64'h3);
    tick();
    a_req = 0;
    chk("rt_strb2", 64'(usr_rd_strb), 1);
    chk("rt_addr2", 64'(usr_addr), 64'h7);
    usr_rd_dvld = 1; usr_rd_data = 36'hAAAA0001;
    tick();
    usr_rd_data = 36'h5555_0002;
    chk("rt_b_dvld", 64'(b_rd_dvld), 1);
    chk("rt_b_data", 64'(b_rd_data), 64'hAAAA0001);
    chk("rt_a_dvld0", 64'(a_rd_dvld), 0);
    chk("rt_err1", 64'(tag_err), 0);
    tick();
    usr_rd_dvld = 0;
    chk("rt_a_dvld", 64'(a_rd_dvld), 1);
    chk("rt_a_data", 64'(a_rd_data), 64'h55550002);
    chk("rt_b_dvld0", 64'(b_rd_dvld), 0);
    chk("rt_err2", 64'(tag_err), 0);

    // contention: both write for 8 cycles from reset
    reset = 1; tick(); reset = 0;
    a_req = 1; a_wr = 1; b_req = 1; b_wr = 1;
    for (int i = 0; i < 8; i++) begin
      logic exp_a;
`ifdef QDR_ARB_RR_EN
      exp_a = (i % 2 == 0);
`else
      exp_a = 1'b1;
`endif
      #1;
      chk($sformatf("cont_a%0d", i), 64'(a_ack), 64'(exp_a));
      chk($sformatf("cont_b%0d", i), 64'(b_ack), 64'(!exp_a));
      tick();
    end
    a_req = 0; b_req = 0;
    tick();

    // fill tag FIFO with 16 A reads
    a_req = 1; a_wr = 0; a_addr = 22'h20;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("fill_ack%0d", i), 64'(a_ack), 1);
      tick();
    end
    chk("full_count", 64'(dut.u_fifo.count), 16);
    b_req = 1; b_wr = 1; b_addr = 22'h30;
    #1;
    chk("full_a_ack", 64'(a_ack), 0);
    chk("full_b_ack", 64'(b_ack), 1);
    tick();
    b_req = 0;
    chk("full_b_issue", 64'(usr_wr_strb), 1);
    #1;
    chk("full_a_blk", 64'(a_ack), 0);
    usr_rd_dvld = 1; usr_rd_data = 36'h777;
    #1;
    chk("pop_same_cyc", 64'(a_ack), 0);
    tick();
    usr_rd_dvld = 0;
    #1;
    chk("pop_a_ack", 64'(a_ack), 1);
    chk("pop_a_dvld", 64'(a_rd_dvld), 1);
    tick();
    a_req = 0;
    chk("refill_count", 64'(dut.u_fifo.count), 16);

    // reset with 3 reads outstanding
    reset = 1; tick(); reset = 0;
    a_req = 1; a_wr = 0;
    tick(); tick(); tick();
    a_req = 0;
    chk("out3_count", 64'(dut.u_fifo.count), 3);
    reset = 1; tick(); reset = 0;
    chk("rst_count", 64'(dut.u_fifo.count), 0);
    usr_rd_dvld = 1;
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tag_err) errs++;
      chk($sformatf("late_a%0d", i), 64'(a_rd_dvld), 0);
      chk($sformatf("late_b%0d", i), 64'(b_rd_dvld), 0);
    end
    usr_rd_dvld = 0;
    chk("late_errs", 64'(errs), 3);
    tick();
    chk("late_err_off", 64'(tag_err), 0);

    // FIFO boundary: push and pop together when full
    f_push = 1;
    for (int i = 0; i < 16; i++) begin
      f_din = (i == 0);
      tick();
    end
    chk("tf_full", 64'(f_full), 1);
    chk("tf_count16", 64'(f_count), 16);
    chk("tf_head", 64'(f_dout), 1);
    f_pop = 1; f_din = 0;
    tick();
    chk("tf_pp_count", 64'(f_count), 16);
    chk("tf_pp_full", 64'(f_full), 1);
    chk("tf_pp_head", 64'(f_dout), 0);
    f_pop = 0;
    tick();
    chk("tf_ovf_count", 64'(f_count), 16);
    f_push = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
